// File: rtl/tl_mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared TileLink-UL definitions for the memory-port arbiter and its users:
//   - A/D channel opcodes
//   - arbiter FSM state encoding
//   - beat_count(): number of A beats carried by one message
// -----------------------------------------------------------------------------
package tl_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_BURST
  } arb_state_e;

  // Puts carry their data on A, so an 8-byte-beat Put of 2^size bytes needs
  // 2^(size-3) beats. Everything else is a single A beat. The port tops out
  // at 64-byte (8-beat) bursts, so larger sizes are clamped to 6.
  function automatic logic [3:0] beat_count(input logic [2:0] opcode,
                                            input logic [2:0] size);
    logic [2:0] sz;
    sz = (size > 3'd6) ? 3'd6 : size;
    if ((opcode == A_PUT_FULL || opcode == A_PUT_PARTIAL) && sz > 3'd3)
      return 4'd1 << (sz - 3'd3);
    return 4'd1;
  endfunction

endpackage

// File: rtl/tl_mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// tl_mem_port_arbiter_if
// Bundles the requester-side and memory-side TileLink-UL A/D signals of the
// memory-port arbiter.
//   master : the arbiter's view (drives *_o, samples *_i)
//   slave  : the environment's view (requesters + memory)
// Requester fields are flat-packed, requester r occupying slice r.
// -----------------------------------------------------------------------------
interface tl_mem_port_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RSRC_W = 2
);
  localparam int SRC_W = RSRC_W + 2;

  // requester A
  logic [NREQ*3-1:0]      req_a_opcode_i;
  logic [NREQ*3-1:0]      req_a_param_i;
  logic [NREQ*3-1:0]      req_a_size_i;
  logic [NREQ*RSRC_W-1:0] req_a_source_i;
  logic [NREQ*ADDR_W-1:0] req_a_address_i;
  logic [NREQ*8-1:0]      req_a_mask_i;
  logic [NREQ*DATA_W-1:0] req_a_data_i;
  logic [NREQ-1:0]        req_a_valid_i;
  logic [NREQ-1:0]        req_a_ready_o;
  // memory A
  logic [2:0]             mem_a_opcode_o;
  logic [2:0]             mem_a_param_o;
  logic [2:0]             mem_a_size_o;
  logic [SRC_W-1:0]       mem_a_source_o;
  logic [ADDR_W-1:0]      mem_a_address_o;
  logic [7:0]             mem_a_mask_o;
  logic [DATA_W-1:0]      mem_a_data_o;
  logic                   mem_a_valid_o;
  logic                   mem_a_ready_i;
  // memory D
  logic [2:0]             mem_d_opcode_i;
  logic [1:0]             mem_d_param_i;
  logic [2:0]             mem_d_size_i;
  logic [SRC_W-1:0]       mem_d_source_i;
  logic                   mem_d_denied_i;
  logic                   mem_d_corrupt_i;
  logic [DATA_W-1:0]      mem_d_data_i;
  logic                   mem_d_valid_i;
  logic                   mem_d_ready_o;
  // requester D (payload broadcast, valid one-hot)
  logic [2:0]             req_d_opcode_o;
  logic [1:0]             req_d_param_o;
  logic [2:0]             req_d_size_o;
  logic [RSRC_W-1:0]      req_d_source_o;
  logic                   req_d_denied_o;
  logic                   req_d_corrupt_o;
  logic [DATA_W-1:0]      req_d_data_o;
  logic [NREQ-1:0]        req_d_valid_o;
  logic [NREQ-1:0]        req_d_ready_i;
  // status
  logic [1:0]             grant_idx_o;
  logic                   route_err_o;

  modport master (
    input  req_a_opcode_i, req_a_param_i, req_a_size_i, req_a_source_i,
           req_a_address_i, req_a_mask_i, req_a_data_i, req_a_valid_i,
           mem_a_ready_i,
           mem_d_opcode_i, mem_d_param_i, mem_d_size_i, mem_d_source_i,
           mem_d_denied_i, mem_d_corrupt_i, mem_d_data_i, mem_d_valid_i,
           req_d_ready_i,
    output req_a_ready_o,
           mem_a_opcode_o, mem_a_param_o, mem_a_size_o, mem_a_source_o,
           mem_a_address_o, mem_a_mask_o, mem_a_data_o, mem_a_valid_o,
           mem_d_ready_o,
           req_d_opcode_o, req_d_param_o, req_d_size_o, req_d_source_o,
           req_d_denied_o, req_d_corrupt_o, req_d_data_o, req_d_valid_o,
           grant_idx_o, route_err_o
  );

  modport slave (
    output req_a_opcode_i, req_a_param_i, req_a_size_i, req_a_source_i,
           req_a_address_i, req_a_mask_i, req_a_data_i, req_a_valid_i,
           mem_a_ready_i,
           mem_d_opcode_i, mem_d_param_i, mem_d_size_i, mem_d_source_i,
           mem_d_denied_i, mem_d_corrupt_i, mem_d_data_i, mem_d_valid_i,
           req_d_ready_i,
    input  req_a_ready_o,
           mem_a_opcode_o, mem_a_param_o, mem_a_size_o, mem_a_source_o,
           mem_a_address_o, mem_a_mask_o, mem_a_data_o, mem_a_valid_o,
           mem_d_ready_o,
           req_d_opcode_o, req_d_param_o, req_d_size_o, req_d_source_o,
           req_d_denied_o, req_d_corrupt_o, req_d_data_o, req_d_valid_o,
           grant_idx_o, route_err_o
  );

endinterface

// File: rtl/tl_mem_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: returns the first asserted request found
// scanning ptr_i, ptr_i+1, ... modulo N. Up to 4 requesters.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle (must be < N)
//   valid_o : at least one request asserted
//   idx_o   : selected index (ptr_i when nothing is requesting)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   ptr_i,
  output logic         valid_o,
  output logic [1:0]   idx_o
);

  always_comb begin
    int best_off;
    int off;
    // NOTE: every output gets a default before the loop so the block can
    // never hold a previous value, which would infer a latch.
    valid_o  = 1'b0;
    idx_o    = ptr_i;
    best_off = N;
    off      = 0;
    // Distance from the pointer decides priority; the smallest distance wins.
    for (int j = 0; j < N; j++) begin
      off = (j + N - int'(ptr_i)) % N;
      if (req_i[j] && off < best_off) begin
        best_off = off;
        valid_o  = 1'b1;
        idx_o    = 2'(j);
      end
    end
  end

endmodule

// File: rtl/tl_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tl_mem_port_arbiter
// Shares one TileLink-UL memory port among NREQ (2..4) requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester A/D, memory A/D, grant_idx_o, route_err_o
// A: round-robin grant, locked while a beat is stalled (HOLD) and for the
//    remaining beats of a multi-beat Put (BURST). The requester index is
//    prepended to the local source.
// D: routed per beat by the index in the top source bits; a beat carrying an
//    index with no requester behind it is sunk and flagged on route_err_o.
// A and D are combinational pass-through; only arbitration state is stored.
// -----------------------------------------------------------------------------
module tl_mem_port_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RSRC_W = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  tl_mem_port_arbiter_if.master bus
);
  import tl_pkg::*;

  localparam int SRC_W = RSRC_W + 2;

  arb_state_e  state_q;
  logic [1:0]  rr_ptr_q;
  logic [1:0]  lock_q;
  logic [3:0]  beats_left_q;
  logic        route_err_q;

  logic              sel_valid;
  logic [1:0]        sel_idx;
  logic [1:0]        cur_idx;
  logic              cur_valid;
  logic [2:0]        cur_opcode, cur_param, cur_size;
  logic [RSRC_W-1:0] cur_source;
  logic [ADDR_W-1:0] cur_address;
  logic [7:0]        cur_mask;
  logic [DATA_W-1:0] cur_data;
  logic [3:0]        cur_beats;
  logic              a_fire;
  logic [1:0]        d_idx;
  logic              d_hit;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (int'(i) == NREQ - 1) ? 2'd0 : i + 2'd1;
  endfunction

  rr_arbiter #(.N(NREQ)) u_rr (
    .req_i   (bus.req_a_valid_i),
    .ptr_i   (rr_ptr_q),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  // Arbitrate only in IDLE; once locked, the locked requester owns channel A.
  assign cur_idx = (state_q == ST_IDLE) ? sel_idx : lock_q;

  always_comb begin
    cur_valid   = 1'b0;
    cur_opcode  = '0;
    cur_param   = '0;
    cur_size    = '0;
    cur_source  = '0;
    cur_address = '0;
    cur_mask    = '0;
    cur_data    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cur_idx == 2'(i)) begin
        cur_valid   = bus.req_a_valid_i[i];
        cur_opcode  = bus.req_a_opcode_i[i*3 +: 3];
        cur_param   = bus.req_a_param_i[i*3 +: 3];
        cur_size    = bus.req_a_size_i[i*3 +: 3];
        cur_source  = bus.req_a_source_i[i*RSRC_W +: RSRC_W];
        cur_address = bus.req_a_address_i[i*ADDR_W +: ADDR_W];
        cur_mask    = bus.req_a_mask_i[i*8 +: 8];
        cur_data    = bus.req_a_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cur_beats = beat_count(cur_opcode, cur_size);

  // ---- channel A outputs (valid/ready held low during reset) ----
  assign bus.mem_a_opcode_o  = cur_opcode;
  assign bus.mem_a_param_o   = cur_param;
  assign bus.mem_a_size_o    = cur_size;
  assign bus.mem_a_source_o  = {cur_idx, cur_source};
  assign bus.mem_a_address_o = cur_address;
  assign bus.mem_a_mask_o    = cur_mask;
  assign bus.mem_a_data_o    = cur_data;
  assign bus.mem_a_valid_o   = rst_n & cur_valid;
  assign a_fire              = bus.mem_a_valid_o & bus.mem_a_ready_i;
  assign bus.grant_idx_o     = rst_n ? cur_idx : 2'd0;

  always_comb begin
    bus.req_a_ready_o = '0;
    for (int i = 0; i < NREQ; i++)
      bus.req_a_ready_o[i] = rst_n & cur_valid & bus.mem_a_ready_i & (cur_idx == 2'(i));
  end

  // ---- arbitration FSM ----
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= 2'd0;
      lock_q       <= 2'd0;
      beats_left_q <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (a_fire) begin
            if (cur_beats == 4'd1) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= next_idx(cur_idx);
            end else begin
              state_q      <= ST_BURST;
              beats_left_q <= cur_beats - 4'd1;
              lock_q       <= cur_idx;
            end
          end else if (state_q == ST_IDLE && sel_valid) begin
            // Stalled first beat: freeze the choice so payload stays stable.
            state_q <= ST_HOLD;
            lock_q  <= sel_idx;
          end
        end
        ST_BURST: begin
          if (a_fire) begin
            beats_left_q <= beats_left_q - 4'd1;
            if (beats_left_q == 4'd1) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= next_idx(lock_q);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---- channel D routing ----
  assign d_idx = bus.mem_d_source_i[SRC_W-1:RSRC_W];
  assign d_hit = int'(d_idx) < NREQ;

  assign bus.req_d_opcode_o  = bus.mem_d_opcode_i;
  assign bus.req_d_param_o   = bus.mem_d_param_i;
  assign bus.req_d_size_o    = bus.mem_d_size_i;
  assign bus.req_d_source_o  = bus.mem_d_source_i[RSRC_W-1:0];
  assign bus.req_d_denied_o  = bus.mem_d_denied_i;
  assign bus.req_d_corrupt_o = bus.mem_d_corrupt_i;
  assign bus.req_d_data_o    = bus.mem_d_data_i;

  always_comb begin
    bus.req_d_valid_o = '0;
    // Unroutable beats are accepted and dropped so D can never wedge.
    bus.mem_d_ready_o = rst_n;
    for (int i = 0; i < NREQ; i++) begin
      if (d_idx == 2'(i)) begin
        bus.req_d_valid_o[i] = rst_n & bus.mem_d_valid_i;
        bus.mem_d_ready_o    = rst_n & bus.req_d_ready_i[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) route_err_q <= 1'b0;
    else        route_err_q <= bus.mem_d_valid_i & ~d_hit;
  end

  assign bus.route_err_o = route_err_q;

endmodule

// File: tb/tb_tl_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tl_mem_port_arbiter
// Directed scenarios followed by randomized traffic, each cycle compared with
// a transaction-level reference model (lock owner + beats remaining + pointer).
// -----------------------------------------------------------------------------
module tb_tl_mem_port_arbiter;
  localparam int NREQ   = 2;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int RSRC_W = 2;
  localparam int SRC_W  = RSRC_W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tl_mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSRC_W(RSRC_W)) bus ();

  tl_mem_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSRC_W(RSRC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---- requester drivers: one message at a time per requester ----
  bit                act  [NREQ];
  logic [2:0]        op   [NREQ];
  logic [2:0]        sz   [NREQ];
  logic [RSRC_W-1:0] src  [NREQ];
  logic [ADDR_W-1:0] addr [NREQ];
  logic [7:0]        msk  [NREQ];
  logic [DATA_W-1:0] dat  [NREQ];
  int                left [NREQ];

  // ---- environment stimulus ----
  bit                s_a_ready;
  bit                s_d_valid;
  logic [SRC_W-1:0]  s_d_src;
  logic [NREQ-1:0]   s_d_ready;
  logic [DATA_W-1:0] s_d_data;
  logic [2:0]        s_d_op;

  // ---- reference model ----
  int m_lock = -1;   // requester owning channel A, -1 if free
  int m_rem  = 0;    // beats of the owner's message still to send (0: not started)
  int m_ptr  = 0;    // first requester considered when free
  bit m_err  = 0;    // route error expected on the next cycle
  int grant_log[$];  // requester of every A beat that fired

  // observed values of the last step
  logic [1:0]       obs_grant;
  logic [SRC_W-1:0] obs_src;
  logic [NREQ-1:0]  obs_rdy;
  logic [ADDR_W-1:0] obs_addr;
  logic [NREQ-1:0]  obs_dvalid;
  logic             obs_dready;
  logic             obs_err;

  function automatic int ref_beats(input logic [2:0] o, input logic [2:0] s);
    int bytes_log2;
    bytes_log2 = (s > 6) ? 6 : int'(s);
    if ((o == 3'd0 || o == 3'd1) && bytes_log2 > 3) return 2 ** (bytes_log2 - 3);
    return 1;
  endfunction

  function automatic bit busy();
    bit b = (m_lock >= 0);
    for (int r = 0; r < NREQ; r++) b |= act[r];
    return b;
  endfunction

  task automatic start_msg(input int r, input logic [2:0] o, input logic [2:0] s,
                           input logic [ADDR_W-1:0] a, input logic [RSRC_W-1:0] sr);
    act[r]  = 1'b1;
    op[r]   = o;
    sz[r]   = s;
    addr[r] = a;
    src[r]  = sr;
    msk[r]  = 8'($urandom);
    dat[r]  = {$urandom, $urandom};
    left[r] = ref_beats(o, s);
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < NREQ; r++) begin
      bus.req_a_valid_i[r]                    = act[r];
      bus.req_a_opcode_i[r*3 +: 3]            = op[r];
      bus.req_a_param_i[r*3 +: 3]             = 3'd0;
      bus.req_a_size_i[r*3 +: 3]              = sz[r];
      bus.req_a_source_i[r*RSRC_W +: RSRC_W]  = src[r];
      bus.req_a_address_i[r*ADDR_W +: ADDR_W] = addr[r];
      bus.req_a_mask_i[r*8 +: 8]              = msk[r];
      bus.req_a_data_i[r*DATA_W +: DATA_W]    = dat[r];
    end
    bus.mem_a_ready_i   = s_a_ready;
    bus.mem_d_valid_i   = s_d_valid;
    bus.mem_d_source_i  = s_d_src;
    bus.mem_d_opcode_i  = s_d_op;
    bus.mem_d_param_i   = 2'd0;
    bus.mem_d_size_i    = 3'd3;
    bus.mem_d_denied_i  = 1'b0;
    bus.mem_d_corrupt_i = s_d_data[0];
    bus.mem_d_data_i    = s_d_data;
    bus.req_d_ready_i   = s_d_ready;
  endtask

  task automatic clear_all();
    for (int r = 0; r < NREQ; r++) begin
      act[r] = 1'b0; op[r] = '0; sz[r] = '0; src[r] = '0;
      addr[r] = '0; msk[r] = '0; dat[r] = '0; left[r] = 0;
    end
    s_a_ready = 1'b0; s_d_valid = 1'b0; s_d_src = '0;
    s_d_ready = '0; s_d_data = '0; s_d_op = '0;
    drive_inputs();
  endtask

  // One clock cycle: drive at negedge, compare 1 time unit later, advance model.
  task automatic step();
    int g;
    bit any;
    int di;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_dv;
    bit exp_dr;
    @(negedge clk);
    drive_inputs();
    #1;
    obs_grant  = bus.grant_idx_o;
    obs_src    = bus.mem_a_source_o;
    obs_rdy    = bus.req_a_ready_o;
    obs_addr   = bus.mem_a_address_o;
    obs_dvalid = bus.req_d_valid_o;
    obs_dready = bus.mem_d_ready_o;
    obs_err    = bus.route_err_o;

    // channel A expectation
    any = 1'b0;
    g   = m_ptr;
    if (m_lock >= 0) begin
      g   = m_lock;
      any = act[g];
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (!any && act[(m_ptr + k) % NREQ]) begin
          g   = (m_ptr + k) % NREQ;
          any = 1'b1;
        end
    end
    exp_rdy = '0;
    if (any && s_a_ready) exp_rdy[g] = 1'b1;
    check("a_valid", bus.mem_a_valid_o, any);
    check("a_ready", obs_rdy, exp_rdy);
    if (any) begin
      check("grant",  obs_grant, g);
      check("a_src",  obs_src, {g[1:0], src[g]});
      check("a_addr", obs_addr, addr[g]);
      check("a_data", bus.mem_a_data_o, dat[g]);
      check("a_op",   bus.mem_a_opcode_o, op[g]);
      check("a_mask", bus.mem_a_mask_o, msk[g]);
    end

    // channel D expectation
    di     = int'(s_d_src[SRC_W-1:RSRC_W]);
    exp_dv = '0;
    exp_dr = 1'b1;
    if (di < NREQ) begin
      if (s_d_valid) exp_dv[di] = 1'b1;
      exp_dr = s_d_ready[di];
    end
    check("d_valid",  obs_dvalid, exp_dv);
    check("d_ready",  obs_dready, exp_dr);
    check("d_source", bus.req_d_source_o, s_d_src[RSRC_W-1:0]);
    check("d_data",   bus.req_d_data_o, s_d_data);
    check("route_err", obs_err, m_err);
    m_err = s_d_valid && di >= NREQ;

    // advance model and drivers across the coming edge
    if (any && s_a_ready) begin
      grant_log.push_back(g);
      if (m_rem == 0) m_rem = ref_beats(op[g], sz[g]);
      m_rem--;
      if (m_rem > 0) m_lock = g;
      else begin
        m_lock = -1;
        m_ptr  = (g + 1) % NREQ;
      end
      left[g]--;
      if (left[g] == 0) act[g] = 1'b0;
      else dat[g] = {$urandom, $urandom};
    end else if (any && m_lock < 0) begin
      m_lock = g;
    end
  endtask

  task automatic drain();
    int n = 0;
    s_d_valid = 1'b0;
    s_a_ready = 1'b1;
    while (busy() && n < 100) begin
      step();
      n++;
    end
    check("drain_bounded", n < 100, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_valid"}, bus.mem_a_valid_o, 1'b0);
    check({tag, "_a_ready"}, bus.req_a_ready_o, '0);
    check({tag, "_d_ready"}, bus.mem_d_ready_o, 1'b0);
    check({tag, "_d_valid"}, bus.req_d_valid_o, '0);
    check({tag, "_grant"},   bus.grant_idx_o, 2'd0);
    check({tag, "_err"},     bus.route_err_o, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    clear_all();
    rst_n  = 1'b1;
    m_lock = -1;
    m_rem  = 0;
    m_ptr  = 0;
    m_err  = 1'b0;
  endtask

  initial begin
    clear_all();
    repeat (2) @(negedge clk);
    // Reset state with active stimulus on every input.
    bus.req_a_valid_i  = '1;
    bus.mem_a_ready_i  = 1'b1;
    bus.mem_d_valid_i  = 1'b1;
    bus.mem_d_source_i = '0;
    bus.req_d_ready_i  = '1;
    #1 check_reset_outputs("rst");
    release_reset();

    // 1) Single Get from req0, then 8 D beats back to it.
    start_msg(0, 3'd4, 3'd6, 64'h100, 2'd1);
    s_a_ready = 1'b1;
    step();
    check("t1_src", obs_src, 4'b0001);
    check("t1_one_beat", grant_log.size(), 1);
    s_d_valid = 1'b1; s_d_src = 4'h1; s_d_op = 3'd1; s_d_ready = 2'b01;
    for (int b = 0; b < 8; b++) begin
      s_d_data = {$urandom, $urandom};
      step();
      check("t1_d_onehot", obs_dvalid, 2'b01);
    end
    s_d_valid = 1'b0;

    // 2) Both requesters issue Gets back to back: grants alternate.
    grant_log.delete();
    for (int c = 0; c < 6; c++) begin
      if (!act[0]) start_msg(0, 3'd4, 3'd3, 64'h200 + 64'(c), 2'd0);
      if (!act[1]) start_msg(1, 3'd4, 3'd3, 64'h300 + 64'(c), 2'd2);
      step();
      if (obs_grant == 2'd1) check("t2_src1", obs_src, 4'b0110);
    end
    for (int i = 0; i < 6; i++) check("t2_alternate", grant_log[i], (1 + i) % 2);
    drain();

    // 3) 8-beat Put from req1 holds the port while req0 waits.
    grant_log.delete();
    start_msg(1, 3'd0, 3'd6, 64'h2000, 2'd3);
    step();
    start_msg(0, 3'd4, 3'd3, 64'h40, 2'd0);
    repeat (8) step();
    check("t3_beats", grant_log.size(), 9);
    for (int i = 0; i < 8; i++) check("t3_burst_owner", grant_log[i], 1);
    check("t3_then_req0", grant_log[8], 0);
    drain();

    // 4) Stalled beat keeps the grant; late requester is not served.
    s_a_ready = 1'b0;
    start_msg(0, 3'd4, 3'd3, 64'h80, 2'd2);
    step();
    start_msg(1, 3'd4, 3'd3, 64'hC0, 2'd1);
    repeat (2) begin
      step();
      check("t4_grant", obs_grant, 2'd0);
      check("t4_ready", obs_rdy, 2'b00);
      check("t4_addr",  obs_addr, 64'h80);
    end
    s_a_ready = 1'b1;
    step();
    check("t4_fire", obs_rdy, 2'b01);
    drain();

    // 5) D beat with an index that has no requester.
    s_d_valid = 1'b1; s_d_src = 4'b1100; s_d_ready = 2'b00;
    step();
    check("t5_d_ready", obs_dready, 1'b1);
    check("t5_d_valid", obs_dvalid, 2'b00);
    s_d_valid = 1'b0;
    step();
    check("t5_err_pulse", obs_err, 1'b1);
    step();
    check("t5_err_clear", obs_err, 1'b0);

    // 6) Reset in the middle of an 8-beat Put.
    start_msg(0, 3'd0, 3'd6, 64'h300, 2'd0);
    s_a_ready = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    bus.mem_d_valid_i  = 1'b1;
    bus.mem_d_source_i = '0;
    bus.req_d_ready_i  = '1;
    #1 check_reset_outputs("t6");
    release_reset();
    start_msg(1, 3'd4, 3'd3, 64'h500, 2'd1);
    s_a_ready = 1'b1;
    step();
    check("t6_grant", obs_grant, 2'd1);
    check("t6_ready", obs_rdy, 2'b10);
    drain();

    // 7) Randomized traffic on A and D.
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NREQ; r++)
        if (!act[r] && $urandom_range(0, 2) == 0) begin
          logic [2:0] o;
          case ($urandom_range(0, 5))
            0, 1:    o = 3'd0;
            2:       o = 3'd1;
            3:       o = 3'd4;
            default: o = 3'($urandom);
          endcase
          start_msg(r, o, 3'($urandom), {$urandom, $urandom}, RSRC_W'($urandom));
        end
      s_a_ready = ($urandom_range(0, 3) != 0);
      s_d_valid = $urandom_range(0, 1);
      s_d_src   = {($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)),
                   RSRC_W'($urandom)};
      s_d_ready = NREQ'($urandom);
      s_d_data  = {$urandom, $urandom};
      s_d_op    = 3'($urandom_range(0, 1));
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
